serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It sequences one full_subractor cell, with ports a, b, c -> d, b0, over WIDTH cycles, LSB first, and holds the borrow in a flip-flop between bits. It computes diff = a_in - b_in and borrow_out = (a_in < b_in, unsigned). It trades latency for area and sits beside the arithmetic datapath as a start/busy/done slave.

---
 rtl/serial_subtractor_ctrl_if.sv | 23 ++
 rtl/serial_subtractor_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and result.
interface serial_subtractor_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   modport master (
      output start, a_in, b_in,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a_in, b_in,
      output busy, done, diff, borrow_out
   );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell is stepped LSB first
// over WIDTH cycles, with the borrow carried between bits in a flip-flop.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input logic                    clk,
   input logic                    rst,
   serial_subtractor_ctrl_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] diff_r;
   logic [WIDTH-1:0] diff_next_s;
   logic [CW-1:0]    cnt_r;
   logic             borrow_r;
   logic             borrow_out_r;
   logic             busy_r;
   logic             done_r;
   logic             cell_d_s;
   logic             cell_b0_s;
   logic             last_bit_s;

   // One full-subtractor cell: returns {difference, borrow-out}.
   function automatic logic [1:0] full_subtractor(input logic a, input logic b, input logic c);
      logic d;
      logic b0;
      d  = a ^ b ^ c;
      b0 = (~a & b) | (~(a ^ b) & c);
      return {d, b0};
   endfunction

   assign {cell_d_s, cell_b0_s} = full_subtractor(sa_r[0], sb_r[0], borrow_r);
   assign last_bit_s = (cnt_r == LAST_CNT);

   generate
      if (WIDTH == 1) begin : g_narrow
         assign diff_next_s = cell_d_s;
      end else begin : g_wide
         assign diff_next_s = {cell_d_s, diff_r[WIDTH-1:1]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_bit_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath and registered status; busy/done track the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa_r         <= {WIDTH{1'b0}};
         sb_r         <= {WIDTH{1'b0}};
         diff_r       <= {WIDTH{1'b0}};
         cnt_r        <= {CW{1'b0}};
         borrow_r     <= 1'b0;
         borrow_out_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         busy_r <= (state_s == ST_RUN);
         done_r <= (state_s == ST_DONE);
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  sa_r     <= bus.a_in;
                  sb_r     <= bus.b_in;
                  borrow_r <= 1'b0;
                  cnt_r    <= {CW{1'b0}};
               end
            end
            ST_RUN: begin
               borrow_r <= cell_b0_s;
               diff_r   <= diff_next_s;
               sa_r     <= sa_r >> 1;
               sb_r     <= sb_r >> 1;
               cnt_r    <= cnt_r + CNT_ONE;
               // Publish the final borrow together with the last difference bit.
               if (last_bit_s) begin
                  borrow_out_r <= cell_b0_s;
               end
            end
            ST_DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.diff       = diff_r;
   assign bus.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random stimulus for the serial subtractor at WIDTH=8 and WIDTH=1,
// checked against plain modular arithmetic and the start-to-done timing rules.
module tb_serial_subtractor_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   serial_subtractor_ctrl_if #(.WIDTH(8)) if8 ();
   serial_subtractor_ctrl_if #(.WIDTH(1)) if1 ();

   serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
   serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation; optionally disturbs start/operands while it runs.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input bit chg);
      int         busy_n, done_n, done_at;
      bit         overlap;
      logic [7:0] d_at, ed;
      logic       bo_at, eb;
      ed = 8'((int'(a) - int'(b) + 256) % 256);
      eb = (int'(a) < int'(b));
      busy_n = 0; done_n = 0; done_at = -1; overlap = 1'b0;
      d_at = 8'bx; bo_at = 1'bx;
      @(negedge clk);
      if8.a_in = a; if8.b_in = b; if8.start = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (n == 1) if8.start = 1'b0;
         if (chg && n == 2) begin
            if8.start = 1'b1; if8.a_in = 8'hAA; if8.b_in = 8'h55;
         end
         if (chg && n == 3) if8.start = 1'b0;
         if (if8.busy === 1'b1) busy_n++;
         if (if8.busy === 1'b1 && if8.done === 1'b1) overlap = 1'b1;
         if (if8.done === 1'b1) begin
            done_n++; done_at = n; d_at = if8.diff; bo_at = if8.borrow_out;
         end
      end
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
      check({tag, "_done_count"}, 64'(done_n), 64'd1);
      check({tag, "_done_latency"}, 64'(done_at), 64'd9);
      check({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
      check({tag, "_diff"}, 64'(d_at), 64'(ed));
      check({tag, "_borrow"}, 64'(bo_at), 64'(eb));
   endtask

   // One WIDTH=1 operation.
   task automatic op1(input string tag, input logic a, input logic b, input logic ed, input logic eb);
      int   busy_n, done_n, done_at;
      logic d_at, bo_at;
      busy_n = 0; done_n = 0; done_at = -1; d_at = 1'bx; bo_at = 1'bx;
      @(negedge clk);
      if1.a_in = a; if1.b_in = b; if1.start = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (n == 1) if1.start = 1'b0;
         if (if1.busy === 1'b1) busy_n++;
         if (if1.done === 1'b1) begin
            done_n++; done_at = n; d_at = if1.diff; bo_at = if1.borrow_out;
         end
      end
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd1);
      check({tag, "_done_count"}, 64'(done_n), 64'd1);
      check({tag, "_done_latency"}, 64'(done_at), 64'd2);
      check({tag, "_diff"}, 64'(d_at), 64'(ed));
      check({tag, "_borrow"}, 64'(bo_at), 64'(eb));
   endtask

   initial begin
      int         done_n, hold_bad, bad_gap, last_done;
      logic [7:0] ra, rb;

      if8.start = 1'b0; if8.a_in = 8'h00; if8.b_in = 8'h00;
      if1.start = 1'b0; if1.a_in = 1'b0;  if1.b_in = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy8", 64'(if8.busy), 64'd0);
      check("rst_done8", 64'(if8.done), 64'd0);
      check("rst_diff8", 64'(if8.diff), 64'd0);
      check("rst_borrow8", 64'(if8.borrow_out), 64'd0);
      check("rst_diff1", 64'(if1.diff), 64'd0);
      check("rst_busy1", 64'(if1.busy), 64'd0);
      rst = 1'b0;

      op8("t1_5a_3c", 8'h5A, 8'h3C, 1'b0);
      op8("t2_00_01", 8'h00, 8'h01, 1'b0);
      op8("t2_ff_ff", 8'hFF, 8'hFF, 1'b0);
      op8("t2_80_7f", 8'h80, 8'h7F, 1'b0);

      op8("t3_10_01", 8'h10, 8'h01, 1'b1);
      hold_bad = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (if8.diff !== 8'h0F || if8.borrow_out !== 1'b0 || if8.done !== 1'b0) hold_bad++;
      end
      check("t3_hold20", 64'(hold_bad), 64'd0);

      // Reset in the 4th RUN cycle of an operation.
      @(negedge clk);
      if8.a_in = 8'h5A; if8.b_in = 8'h3C; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_busy_before_rst", 64'(if8.busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t4_busy", 64'(if8.busy), 64'd0);
      check("t4_done", 64'(if8.done), 64'd0);
      check("t4_diff", 64'(if8.diff), 64'd0);
      check("t4_borrow", 64'(if8.borrow_out), 64'd0);
      done_n = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (if8.done === 1'b1) done_n++;
      end
      check("t4_no_done", 64'(done_n), 64'd0);
      op8("t4_03_05", 8'h03, 8'h05, 1'b0);

      // start held high: a new operation on every return to IDLE.
      @(negedge clk);
      if8.a_in = 8'h20; if8.b_in = 8'h21; if8.start = 1'b1;
      done_n = 0; bad_gap = 0; last_done = -1; hold_bad = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 40) if8.start = 1'b0;
         if (if8.done === 1'b1) begin
            done_n++;
            if (if8.diff !== 8'hFF || if8.borrow_out !== 1'b1) hold_bad++;
            if (last_done < 0 && n != 9) bad_gap++;
            if (last_done >= 0 && n - last_done != 10) bad_gap++;
            last_done = n;
         end
      end
      check("t5_done_count", 64'(done_n), 64'd4);
      check("t5_spacing", 64'(bad_gap), 64'd0);
      check("t5_results", 64'(hold_bad), 64'd0);
      repeat (4) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         op8($sformatf("rnd%0d", i), ra, rb, 1'b0);
      end

      op1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0);
      op1("w1_01", 1'b0, 1'b1, 1'b1, 1'b1);
      op1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0);
      op1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
